hilo_muldiv_unit: RTL

Parametrised HI/LO register pair with an integrated iterative multiply/divide sequencer. It replaces the plain HI/LO register in the execute stage: it holds the two DATA_W-bit result registers, accepts move-to-HI/LO writes, and runs signed/unsigned multiply and divide over several cycles. A Busy/Done handshake lets the pipeline controller stall MFHI/MFLO until results are valid.

---
 rtl/hilo_pkg.sv | 39 +++
 rtl/hilo_iter_datapath.sv | 65 ++++++
 rtl/hilo_muldiv_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Shared types and width-dependent constants for the HI/LO multiply/divide unit.
package hilo_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  // Callers truncate the MAX_W-wide result to their own width.
  function automatic logic [MAX_W-1:0] most_neg(input int w);
    logic [MAX_W-1:0] v;
    v = '0;
    v[w-1] = 1'b1;
    return v;
  endfunction

  function automatic logic [MAX_W-1:0] all_ones(input int w);
    return {MAX_W{1'b1}} >> (MAX_W - w);
  endfunction

endpackage

// File: rtl/hilo_iter_datapath.sv
// Shift register, shared DATA_W+1-bit add/subtract step and down-counter used by
// both shift-add multiply and restoring divide; sequenced by the parent FSM.
module hilo_iter_datapath #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              last
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] b_r;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W:0]   div_shift;
  logic [DATA_W:0]   x;
  logic [DATA_W:0]   y;
  logic [DATA_W+1:0] sum;

  // Divide subtracts via inverted operand plus carry-in; carry out means no borrow.
  always_comb begin
    div_shift = {hi, lo[DATA_W-1]};
    if (is_div) begin
      x = div_shift;
      y = ~{1'b0, b_r};
    end else begin
      x = {1'b0, hi};
      y = lo[0] ? {1'b0, b_r} : '0;
    end
    sum = {1'b0, x} + {1'b0, y} + {{(DATA_W+1){1'b0}}, is_div};
  end

  assign last = (cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      hi  <= '0;
      lo  <= '0;
      b_r <= '0;
      cnt <= '0;
    end else if (load) begin
      hi  <= '0;
      lo  <= opa;
      b_r <= opb;
      cnt <= CNT_W'(DATA_W);
    end else if (step) begin
      cnt <= cnt - CNT_W'(1);
      if (is_div) begin
        hi <= sum[DATA_W+1] ? sum[DATA_W-1:0] : div_shift[DATA_W-1:0];
        lo <= {lo[DATA_W-2:0], sum[DATA_W+1]};
      end else begin
        hi <= sum[DATA_W:1];
        lo <= {sum[0], lo[DATA_W-1:1]};
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with iterative signed/unsigned multiply and divide.
// Define HILO_MADD_EN to build MADD/MADDU/MSUB/MSUBU (ops 7-10); otherwise they are illegal.
//
// state   | meaning
// IDLE    | accepts Start; MTHI/MTLO write directly
// MUL     | DATA_W shift-add iterations on magnitudes
// DIV     | DATA_W restoring-divide iterations on magnitudes
// FIX     | sign fix / accumulate, commit Hi/Lo
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [3:0]        Op,
  input  logic [DATA_W-1:0] OperandA,
  input  logic [DATA_W-1:0] OperandB,
  output logic              Busy,
  output logic              Done,
  output logic              DivByZero,
  output logic              IllegalOp,
  output logic [DATA_W-1:0] Hi,
  output logic [DATA_W-1:0] Lo
);

  localparam logic [DATA_W-1:0] MOST_NEG = DATA_W'(most_neg(DATA_W));
  localparam logic [DATA_W-1:0] ALL_ONES = DATA_W'(all_ones(DATA_W));

  state_e state, state_nx;

  logic [3:0]          op_r;
  logic                neg_res, neg_rem, dz_r, div_r;
  logic [DATA_W-1:0]   a_raw;
  logic                load, step, last, commit, wr_hi, wr_lo, illegal;
  logic                is_signed, is_div_op, sign_a, sign_b;
  logic [DATA_W-1:0]   mag_a, mag_b, dp_hi, dp_lo, quot, rem;
  logic [2*DATA_W-1:0] prod, acc;

  assign is_signed = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);
  assign is_div_op = (Op == OP_DIV) || (Op == OP_DIVU);
  assign sign_a    = is_signed && ((OperandA & MOST_NEG) != '0);
  assign sign_b    = is_signed && ((OperandB & MOST_NEG) != '0);
  assign mag_a     = sign_a ? -OperandA : OperandA;
  assign mag_b     = sign_b ? -OperandB : OperandB;
  assign div_r     = (op_r == OP_DIV) || (op_r == OP_DIVU);
  assign Busy      = (state != ST_IDLE);

  hilo_iter_datapath #(.DATA_W(DATA_W)) u_dp (
    .clk    (Clock),
    .rst_b  (Reset),
    .load   (load),
    .step   (step),
    .is_div (state == ST_DIV),
    .opa    (mag_a),
    .opb    (mag_b),
    .hi     (dp_hi),
    .lo     (dp_lo),
    .last   (last)
  );

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    commit   = 1'b0;
    wr_hi    = 1'b0;
    wr_lo    = 1'b0;
    illegal  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start) begin
          case (Op)
            OP_NOP: ;
            OP_MTHI: wr_hi = 1'b1;
            OP_MTLO: wr_lo = 1'b1;
            OP_MULT, OP_MULTU: begin
              load     = 1'b1;
              state_nx = ST_MUL;
            end
`ifdef HILO_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              load     = 1'b1;
              state_nx = ST_MUL;
            end
`endif
            OP_DIV, OP_DIVU: begin
              load     = 1'b1;
              state_nx = ST_DIV;
            end
            default: illegal = 1'b1;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        step = 1'b1;
        if (last) state_nx = ST_FIX;
      end
      ST_FIX: begin
        commit   = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    prod = {dp_hi, dp_lo};
    if (neg_res) prod = -prod;
`ifdef HILO_MADD_EN
    case (op_r)
      OP_MADD, OP_MADDU: acc = {Hi, Lo} + prod;
      OP_MSUB, OP_MSUBU: acc = {Hi, Lo} - prod;
      default:           acc = prod;
    endcase
`else
    acc = prod;
`endif
    quot = neg_res ? -dp_lo : dp_lo;
    rem  = neg_rem ? -dp_hi : dp_hi;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state     <= ST_IDLE;
      Hi        <= '0;
      Lo        <= '0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      IllegalOp <= 1'b0;
      op_r      <= OP_NOP;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      dz_r      <= 1'b0;
      a_raw     <= '0;
    end else begin
      state     <= state_nx;
      Done      <= commit | wr_hi | wr_lo;
      DivByZero <= commit & div_r & dz_r;
      IllegalOp <= illegal;
      if (load) begin
        op_r    <= Op;
        neg_res <= sign_a ^ sign_b;
        neg_rem <= sign_a;
        dz_r    <= is_div_op && (OperandB == '0);
        a_raw   <= OperandA;
      end
      if (wr_hi) Hi <= OperandA;
      if (wr_lo) Lo <= OperandA;
      // Divide by zero reports the raw dividend, not the magnitude the datapath saw.
      if (commit) begin
        if (div_r) begin
          if (dz_r) {Hi, Lo} <= {a_raw, ALL_ONES};
          else      {Hi, Lo} <= {rem, quot};
        end else begin
          {Hi, Lo} <= acc;
        end
      end
    end
  end

endmodule
